// File: rtl/fb_pixel_fetch.sv
// fb_pixel_fetch -- frame buffer pixel prefetcher.
//
// Streams one frame of pixels from memory into a small FIFO. Reads are issued
// only while there is room for every response (credit flow control), so the
// FIFO can never overflow. frame_start restarts the frame from any state. Reads
// that are still in flight at that point are dropped when their data returns.
//
// Parameters:
//   ADDR_W       memory address width
//   DATA_W       pixel / memory data width
//   FRAME_PIXELS pixels per frame
//   BASE_ADDR    address of the first pixel of the frame
//   FIFO_DEPTH   pixel buffer entries (power of two, >= 2)
//
// Ports:
//   clk          pixel clock, the only clock
//   rst_n        asynchronous active-low reset
//   frame_start  one-cycle pulse: flush the FIFO and restart the frame
//   mem_req      read request valid
//   mem_addr     read address, held while mem_req=1 and mem_gnt=0
//   mem_gnt      request accepted this cycle (when mem_req=1)
//   mem_rvalid   read data valid, returned in request order
//   mem_rdata    read data
//   pix_pop      consumer takes pix_data this cycle
//   pix_data     FIFO head pixel, 0 when the FIFO is empty
//   pix_valid    FIFO not empty
//   underflow    sticky: a pop happened while the FIFO was empty
//
// Optional feature (macro FB_UNDERFLOW_CNT_EN):
//   underflow_cnt [15:0] counts empty pops, saturates at 16'hFFFF,
//   cleared only by reset.

module fb_pixel_fetch #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 4,
  parameter int FRAME_PIXELS = 307200,
  parameter int BASE_ADDR    = 0,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow
`ifdef FB_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);

  localparam int PC_W = $clog2(FRAME_PIXELS + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] BASE_L   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]   LAST_CNT = PC_W'(FRAME_PIXELS - 1);
  localparam logic [PC_W-1:0]   PC_ZERO  = {PC_W{1'b0}};
  localparam logic [PC_W-1:0]   PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     C_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]     C_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]       DEPTH_W  = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]     P_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0]     P_ONE    = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_fifo_cnt;
  logic [CW-1:0]     r_outst;
  logic [CW-1:0]     r_discard;
  logic [PC_W-1:0]   r_pix_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_underflow;

  logic [CW:0]       w_used;
  logic              w_active;
  logic              w_grant;
  logic              w_rsp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_empty_pop;

  // Reads granted but not yet returned already own a FIFO slot, so the
  // credit is whatever is left after the stored pixels and those reads.
  assign w_used      = {1'b0, r_fifo_cnt} + {1'b0, r_outst};
  assign w_active    = (r_state != ST_IDLE);
  assign mem_req     = (r_state == ST_FETCH) && !frame_start && (w_used < DEPTH_W);
  assign w_grant     = mem_req && mem_gnt;

  // Responses only count while a frame is active; after a reset the block
  // sits in IDLE and any stale beats fall on the floor.
  assign w_rsp       = mem_rvalid && w_active && (r_outst != C_ZERO);
  assign w_drop      = w_rsp && (r_discard != C_ZERO);
  assign w_push      = w_rsp && !w_drop && !frame_start && (r_fifo_cnt != DEPTH_C);
  assign w_pop       = pix_pop && (r_fifo_cnt != C_ZERO);
  assign w_empty_pop = pix_pop && (r_fifo_cnt == C_ZERO);

  assign pix_valid   = (r_fifo_cnt != C_ZERO);
  assign pix_data    = pix_valid ? r_mem[r_rd_ptr] : {DATA_W{1'b0}};
  assign mem_addr    = r_addr;
  assign underflow   = r_underflow;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: frame_start overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      w_state_nxt = ST_FETCH;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_FETCH: begin
          if (w_grant && (r_pix_cnt == LAST_CNT)) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (r_outst == C_ZERO) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Request address, granted-pixel count, outstanding and discard counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= BASE_L;
      r_pix_cnt <= PC_ZERO;
      r_outst   <= C_ZERO;
      r_discard <= C_ZERO;
    end else if (frame_start) begin
      // Every read still in flight belongs to the old frame; a beat
      // returning in this very cycle is already accounted for.
      r_addr    <= BASE_L;
      r_pix_cnt <= PC_ZERO;
      r_outst   <= w_rsp ? (r_outst - C_ONE) : r_outst;
      r_discard <= w_rsp ? (r_outst - C_ONE) : r_outst;
    end else begin
      if (w_grant) begin
        r_pix_cnt <= r_pix_cnt + PC_ONE;
        // The last grant leaves the address on the final pixel.
        if (r_pix_cnt != LAST_CNT) begin
          r_addr <= r_addr + ADDR_ONE;
        end
      end
      case ({w_grant, w_rsp})
        2'b10:   r_outst <= r_outst + C_ONE;
        2'b01:   r_outst <= r_outst - C_ONE;
        default: r_outst <= r_outst;
      endcase
      if (w_drop) begin
        r_discard <= r_discard - C_ONE;
      end
    end
  end

  // FIFO pointers and occupancy; frame_start flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= P_ZERO;
      r_rd_ptr   <= P_ZERO;
      r_fifo_cnt <= C_ZERO;
    end else if (frame_start) begin
      r_wr_ptr   <= P_ZERO;
      r_rd_ptr   <= P_ZERO;
      r_fifo_cnt <= C_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + P_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + P_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + C_ONE;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - C_ONE;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until the count says otherwise.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= mem_rdata;
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow <= 1'b0;
    end else if (w_empty_pop) begin
      r_underflow <= 1'b1;
    end
  end

`ifdef FB_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow_cnt;

  assign underflow_cnt = r_underflow_cnt;

  // Saturating count of pops taken while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow_cnt <= 16'h0000;
    end else if (w_empty_pop && (r_underflow_cnt != 16'hFFFF)) begin
      r_underflow_cnt <= r_underflow_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/fb_pixel_fetch.md
FB_PIXEL_FETCH -- requirements
Module: fb_pixel_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, memory address width.
REQ-002 SHALL have parameter DATA_W, default 4, pixel/memory data width.
REQ-003 SHALL have parameter FRAME_PIXELS, default 307200 (640x480), pixels per frame.
REQ-004 SHALL have parameter BASE_ADDR, default 0, address of the first frame pixel.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, power of two, pixel buffer entries.
REQ-006 SHALL have port clk, input, 1: single clock for all logic, the pixel clock.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port frame_start, input, 1: one-cycle pulse from the timing generator that restarts the frame.
REQ-009 SHALL have port mem_req, output, 1: read request valid.
REQ-010 SHALL have port mem_addr, output, ADDR_W: read address, stable while mem_req=1 and mem_gnt=0.
REQ-011 SHALL have port mem_gnt, input, 1: request accepted this cycle when mem_req=1.
REQ-012 SHALL have port mem_rvalid, input, 1: read data valid, returned in request order.
REQ-013 SHALL have port mem_rdata, input, DATA_W: read data.
REQ-014 SHALL have port pix_pop, input, 1: pixel consumer takes pix_data this cycle.
REQ-015 SHALL have port pix_data, output, DATA_W: FIFO head pixel; 0 when empty.
REQ-016 SHALL have port pix_valid, output, 1: FIFO not empty.
REQ-017 SHALL have port underflow, output, 1: sticky flag, pop while empty.

Function
REQ-018 SHALL implement FSM IDLE -> FETCH on frame_start; FETCH -> DRAIN after FRAME_PIXELS requests granted; DRAIN -> IDLE when outstanding count reaches 0.
REQ-019 SHALL assert mem_req in FETCH only when credit = FIFO_DEPTH - fifo_count - outstanding > 0.
REQ-020 SHALL increment mem_addr by 1 on each grant, starting at BASE_ADDR, never exceeding BASE_ADDR+FRAME_PIXELS-1.
REQ-021 SHALL count outstanding reads: +1 on grant, -1 on mem_rvalid, both in the same cycle leave it unchanged.
REQ-022 SHALL write mem_rdata into the FIFO on mem_rvalid unless the response is being discarded (REQ-025); FIFO never overflows by credit construction.
REQ-023 SHALL present the FIFO head combinationally on pix_data with zero-cycle pop latency; a simultaneous push and pop keeps the count unchanged.
REQ-024 SHALL, on pix_pop with FIFO empty, leave FIFO unchanged, drive pix_data=0, and set underflow until reset.
REQ-025 SHALL, on frame_start in any state, flush the FIFO, reload mem_addr to BASE_ADDR, enter FETCH, load a discard counter with in-flight reads, and drop that many subsequent mem_rvalid beats.
REQ-026 SHALL NOT issue a new request in the frame_start cycle; requests resume the next cycle.
REQ-027 SHALL size counters as $clog2(FRAME_PIXELS+1) for the pixel count and $clog2(FIFO_DEPTH+1) for fifo_count, outstanding and discard.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, mem_req=0, mem_addr=BASE_ADDR, FIFO empty, pix_valid=0, pix_data=0, underflow=0, all counters 0.
REQ-029 SHALL, on reset mid-frame, drop in-flight responses implicitly by remaining IDLE until frame_start; mem_rvalid in IDLE is ignored.

Configuration
REQ-030 SHALL, with FB_UNDERFLOW_CNT_EN defined, add output underflow_cnt [15:0], incremented per empty pop, saturating at 16'hFFFF, cleared only by reset.
REQ-031 SHALL, without FB_UNDERFLOW_CNT_EN, omit underflow_cnt and its logic; all other behaviour identical.

Verification
REQ-032 Reset then frame_start, mem_gnt=1, rvalid 2 cycles after grant, no pops -> exactly 8 requests at addresses 0..7, then mem_req=0, pix_valid=1.
REQ-033 FRAME_PIXELS=16, continuous pop when pix_valid -> 16 pixels out in address order, state returns to IDLE, mem_req never asserted after address 15.
REQ-034 Pop with FIFO empty after reset -> pix_data=0, underflow=1 and stays 1; with FB_UNDERFLOW_CNT_EN, 3 such pops -> underflow_cnt=3.
REQ-035 frame_start with 3 reads outstanding -> next 3 mem_rvalid beats discarded, first stored pixel is from address BASE_ADDR.
REQ-036 mem_gnt held 0 for 5 cycles -> mem_req stays 1 and mem_addr constant until the grant.
REQ-037 rst_n deasserted mid-FETCH with outstanding reads -> all outputs at reset values asynchronously, no FIFO writes until the next frame_start.
